fifo_bus_drain: RTL and testbench

FIFO_BUS_DRAIN -- requirements
Module: fifo_bus_drain

---
 rtl/fifo_bus_drain_pkg.sv | 22 ++
 rtl/drain_line_buffer.sv | 42 ++++
 rtl/fifo_bus_drain.sv | 197 +++++++++++++++++++
 tb/tb_fifo_bus_drain.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_bus_drain_pkg.sv
// Shared types and constants for the FIFO-to-bus drain engine.
// The state encoding, word/byte address shift and burst-length width live here.
package fifo_bus_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_REQUEST,
        ST_BEGIN,
        ST_DATA,
        ST_END,
        ST_FINISH
    } drain_state_e;

    localparam int WORD_SHIFT  = 2;
    localparam int BURST_LEN_W = 8;

    function automatic logic [31:0] words_to_bytes(input logic [15:0] words);
        return {16'd0, words} << WORD_SHIFT;
    endfunction

endpackage

// File: rtl/drain_line_buffer.sv
// Chunk store: words are appended in arrival order and read back by index.
// clear (or reset) empties the store; the word contents themselves are not reset.
module drain_line_buffer #(
    parameter int bitWidth = 32,
    parameter int depth    = 8,
    localparam int IDX_W   = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                wrEn,
    input  logic [bitWidth-1:0] wrData,
    input  logic [IDX_W-1:0]    rdIdx,
    output logic [bitWidth-1:0] rdData,
    output logic [IDX_W:0]      count
);

    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(depth);

    logic [bitWidth-1:0] mem_q [depth];
    logic [IDX_W:0]      count_q;
    logic                full;

    assign full   = (count_q == DEPTH_CNT);
    assign count  = count_q;
    assign rdData = mem_q[rdIdx];

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (wrEn && !full) begin
            count_q <= count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wrEn && !full) begin
            mem_q[count_q[IDX_W-1:0]] <= wrData;
        end
    end

endmodule

// File: rtl/fifo_bus_drain.sv
// Drains an upstream FIFO onto a burst bus in chunks of min(burstSize, remaining) words.
// Build option: define BYTE_SWAP_EN to byte-reverse every data word on addressData.
module fifo_bus_drain
    import fifo_bus_drain_pkg::*;
#(
    parameter int bitWidth  = 32,
    parameter int burstSize = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            startAddress,
    input  logic [15:0]            nrOfWords,
    input  logic                   fifoEmpty,
    input  logic [bitWidth-1:0]    fifoPopData,
    output logic                   fifoPop,
    output logic                   requestBus,
    input  logic                   busGrant,
    output logic                   beginTransaction,
    output logic                   endTransaction,
    output logic [31:0]            addressData,
    output logic [BURST_LEN_W-1:0] burstLength,
    output logic                   dataValid,
    input  logic                   busBusy,
    input  logic                   busError,
    output logic                   busyOut,
    output logic                   done,
    output logic                   error
);

    localparam int          IDX_W       = (burstSize > 1) ? $clog2(burstSize) : 1;
    localparam logic [15:0] BURST_WORDS = 16'(burstSize);

    drain_state_e        state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [IDX_W-1:0]    beat_q, beat_d;
    logic                popPending_q, popPending_d;
    logic                error_q, error_d;
    logic                abort_q, abort_d;

    logic [15:0]         chunk;
    logic [15:0]         inFlight;
    logic [IDX_W:0]      storedCount;
    logic [bitWidth-1:0] storedWord;
    logic [bitWidth-1:0] busWord;
    logic                bufClear;
    logic                unusedAddrBits;

    assign unusedAddrBits = ^startAddress[1:0];

    assign chunk    = (remaining_q < BURST_WORDS) ? remaining_q : BURST_WORDS;
    assign inFlight = 16'(storedCount) + 16'(popPending_q);
    assign bufClear = (state_q == ST_END);

    drain_line_buffer #(
        .bitWidth(bitWidth),
        .depth   (burstSize)
    ) u_line_buffer (
        .clock (clock),
        .reset (reset),
        .clear (bufClear),
        .wrEn  (popPending_q),
        .wrData(fifoPopData),
        .rdIdx (beat_q),
        .rdData(storedWord),
        .count (storedCount)
    );

`ifdef BYTE_SWAP_EN
    function automatic logic [bitWidth-1:0] byte_swap(input logic [bitWidth-1:0] w);
        logic [bitWidth-1:0] r;
        r = w;
        for (int i = 0; i < bitWidth / 8; i++) begin
            r[i*8 +: 8] = w[bitWidth-8-i*8 +: 8];
        end
        return r;
    endfunction

    assign busWord = byte_swap(storedWord);
`else
    assign busWord = storedWord;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            beat_q       <= '0;
            popPending_q <= 1'b0;
            error_q      <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            beat_q       <= beat_d;
            popPending_q <= popPending_d;
            error_q      <= error_d;
            abort_q      <= abort_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        remaining_d      = remaining_q;
        beat_d           = beat_q;
        error_d          = error_q;
        abort_d          = abort_q;
        fifoPop          = 1'b0;
        requestBus       = 1'b0;
        beginTransaction = 1'b0;
        endTransaction   = 1'b0;
        addressData      = 32'd0;
        burstLength      = '0;
        dataValid        = 1'b0;
        done             = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    error_d     = 1'b0;
                    abort_d     = 1'b0;
                    addr_d      = {startAddress[31:2], 2'b00};
                    remaining_d = nrOfWords;
                    state_d     = (nrOfWords == 16'd0) ? ST_FINISH : ST_FILL;
                end
            end
            // A popped word lands one cycle later, so in-flight pops count against the chunk.
            ST_FILL: begin
                fifoPop = !fifoEmpty && (inFlight < chunk);
                if (16'(storedCount) == chunk) begin
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                requestBus = 1'b1;
                if (busGrant) begin
                    state_d = ST_BEGIN;
                end
            end
            ST_BEGIN: begin
                requestBus       = 1'b1;
                beginTransaction = 1'b1;
                addressData      = addr_q;
                burstLength      = BURST_LEN_W'(chunk - 16'd1);
                beat_d           = '0;
                if (busError) begin
                    error_d = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_END;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                requestBus  = 1'b1;
                dataValid   = 1'b1;
                addressData = 32'(busWord);
                if (busError) begin
                    error_d = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_END;
                end else if (!busBusy) begin
                    if (16'(beat_q) == chunk - 16'd1) begin
                        state_d = ST_END;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            // An aborted burst still closes the bus transaction before finishing.
            ST_END: begin
                requestBus     = 1'b1;
                endTransaction = 1'b1;
                addr_d         = addr_q + words_to_bytes(chunk);
                remaining_d    = remaining_q - chunk;
                state_d        = (abort_q || (remaining_q == chunk)) ? ST_FINISH : ST_FILL;
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        popPending_d = fifoPop;
    end

    assign busyOut = (state_q != ST_IDLE);
    assign error   = error_q;

endmodule

// File: tb/tb_fifo_bus_drain.sv
// Randomized self-checking bench for fifo_bus_drain against a chunking reference model.
// Models the upstream FIFO (one-cycle pop latency) and a bus slave with stall/error injection.
module tb_fifo_bus_drain;

    localparam int BS = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] startAddress = 32'd0;
    logic [15:0] nrOfWords = 16'd0;
    logic        fifoEmpty;
    logic [31:0] fifoPopData = 32'd0;
    logic        fifoPop;
    logic        requestBus;
    logic        busGrant;
    logic        beginTransaction;
    logic        endTransaction;
    logic [31:0] addressData;
    logic [7:0]  burstLength;
    logic        dataValid;
    logic        busBusy;
    logic        busError;
    logic        busyOut;
    logic        done;
    logic        error;

    fifo_bus_drain #(.bitWidth(32), .burstSize(BS)) dut (
        .clock(clock), .reset(reset), .start(start), .startAddress(startAddress),
        .nrOfWords(nrOfWords), .fifoEmpty(fifoEmpty), .fifoPopData(fifoPopData),
        .fifoPop(fifoPop), .requestBus(requestBus), .busGrant(busGrant),
        .beginTransaction(beginTransaction), .endTransaction(endTransaction),
        .addressData(addressData), .burstLength(burstLength), .dataValid(dataValid),
        .busBusy(busBusy), .busError(busError), .busyOut(busyOut), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // upstream FIFO model
    logic [31:0] fifoQ[$];
    int          wrCount = 0;
    int          rdCount = 0;
    logic        starve = 1'b0;
    assign fifoEmpty = (wrCount == rdCount) || starve;

    // bus slave model
    logic grantOk = 1'b1, randBusy = 1'b0, randGrantEn = 1'b0, randBusyEn = 1'b0;
    logic busyArm = 1'b0, errArm = 1'b0;
    int   busyBeat = 0, busyCycles = 0, errBeat = 0;
    int   beatInBurst = 0, busyCnt = 0;
    logic accFlag = 1'b0, busyFlag = 1'b0, beginFlag = 1'b0;
    assign busGrant = requestBus && grantOk;
    assign busBusy  = dataValid && (randBusy || (busyArm && beatInBurst == busyBeat && busyCnt < busyCycles));
    assign busError = dataValid && errArm && (beatInBurst == errBeat);

    always @(posedge clock) begin
        if (fifoPop && !fifoEmpty) begin
            fifoPopData <= fifoQ.pop_front();
            rdCount <= rdCount + 1;
        end
        if (beginFlag) begin
            beatInBurst <= 0; busyCnt <= 0;
        end else if (accFlag) begin
            beatInBurst <= beatInBurst + 1; busyCnt <= 0;
        end else if (busyFlag) begin
            busyCnt <= busyCnt + 1;
        end
        grantOk  <= randGrantEn ? 1'($urandom_range(0, 1)) : 1'b1;
        randBusy <= randBusyEn && ($urandom_range(0, 2) == 0);
    end

    // bus/FIFO observer, sampled mid-cycle
    logic [31:0] bAddr[$], dData[$];
    logic [7:0]  bLen[$];
    int   nPops = 0, nBadPop = 0, nDone = 0, nEnd = 0, nDv = 0, nBadOut = 0, nBadHold = 0;
    logic prevBusy = 1'b0;
    logic [31:0] prevData = 32'd0;

    always @(negedge clock) begin
        accFlag   <= dataValid && !busBusy && !busError;
        busyFlag  <= dataValid && busBusy && !busError;
        beginFlag <= beginTransaction;
        if (beginTransaction) begin
            bAddr.push_back(addressData);
            bLen.push_back(burstLength);
        end
        if (dataValid) nDv <= nDv + 1;
        if (dataValid && !busBusy && !busError) dData.push_back(addressData);
        if (endTransaction) nEnd <= nEnd + 1;
        if (done) nDone <= nDone + 1;
        if (fifoPop) nPops <= nPops + 1;
        if (fifoPop && fifoEmpty) nBadPop <= nBadPop + 1;
        if ((!beginTransaction && !dataValid && addressData != 32'd0) ||
            (!beginTransaction && burstLength != 8'd0)) nBadOut <= nBadOut + 1;
        if (prevBusy && !(dataValid && addressData == prevData)) nBadHold <= nBadHold + 1;
        prevBusy <= dataValid && busBusy && !busError;
        prevData <= addressData;
    end

    // reference model: chunk the transfer, predict bursts, beats and pops
    logic [31:0] expA[$], expD[$];
    logic [7:0]  expL[$];
    int          expPops;

    function automatic logic [31:0] swap(input logic [31:0] w);
`ifdef BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic void model(input logic [31:0] a, input int n, input int errB);
        int rem = n, idx = 0, c;
        logic [31:0] ad = a & 32'hFFFF_FFFC;
        expA.delete(); expL.delete(); expD.delete(); expPops = 0;
        while (rem > 0) begin
            c = (rem < BS) ? rem : BS;
            expA.push_back(ad);
            expL.push_back(8'(c - 1));
            expPops += c;
            for (int i = 0; i < c; i++)
                if (errB < 0 || i < errB) expD.push_back(swap(fifoQ[idx + i]));
            if (errB >= 0) break;
            idx += c; ad += 32'(c * 4); rem -= c;
        end
    endfunction

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) fifoQ.push_back($urandom);
        wrCount += n;
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
        @(negedge clock);
        startAddress = a; nrOfWords = n; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int e0, output bit timedOut);
        int k = 0;
        while (nDone == e0 && k < 4000) begin @(negedge clock); k++; end
        timedOut = (nDone == e0);
        repeat (2) @(negedge clock);
    endtask

    task automatic run_xfer(input logic [31:0] a, input logic [15:0] n, output bit timedOut);
        int e0 = nDone;
        pulse_start(a, n);
        wait_done(e0, timedOut);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if ({busyOut, fifoPop, requestBus, beginTransaction, endTransaction, dataValid, done, error} !== 8'h00) begin
            fails++; $display("FAIL reset_ctrl: got %b want 00000000",
                {busyOut, fifoPop, requestBus, beginTransaction, endTransaction, dataValid, done, error});
        end
        tests++;
        if (addressData !== 32'd0 || burstLength !== 8'd0) begin
            fails++; $display("FAIL reset_bus: got addr %h len %0d want 0/0", addressData, burstLength);
        end
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if (busyOut !== 1'b0) begin fails++; $display("FAIL reset_idle: busyOut %b want 0", busyOut); end
    endtask

    task automatic test_single_burst();
        int b0 = bAddr.size(), d0 = dData.size(), p0 = nPops, e0 = nDone;
        bit to;
        for (int i = 0; i < 8; i++) fifoQ.push_back(32'(i + 1));
        wrCount += 8;
        run_xfer(32'h1000, 16'd8, to);
        tests++; if (to) begin fails++; $display("FAIL single_done_timeout: no done seen"); end
        tests++; if (bAddr.size() - b0 != 1) begin fails++; $display("FAIL single_bursts: got %0d want 1", bAddr.size() - b0); end
        tests++; if (bAddr[b0] !== 32'h1000 || bLen[b0] !== 8'd7) begin
            fails++; $display("FAIL single_hdr: got %h/%0d want 00001000/7", bAddr[b0], bLen[b0]); end
        tests++; if (dData.size() - d0 != 8) begin fails++; $display("FAIL single_beats: got %0d want 8", dData.size() - d0); end
        for (int i = 0; i < 8 && d0 + i < dData.size(); i++) begin
            tests++; if (dData[d0 + i] !== swap(32'(i + 1))) begin
                fails++; $display("FAIL single_data%0d: got %h want %h", i, dData[d0 + i], swap(32'(i + 1))); end
        end
        tests++; if (nDone - e0 != 1) begin fails++; $display("FAIL single_done_count: got %0d want 1", nDone - e0); end
        tests++; if (nPops - p0 != 8) begin fails++; $display("FAIL single_pops: got %0d want 8", nPops - p0); end
        tests++; if (busyOut !== 1'b0 || error !== 1'b0) begin
            fails++; $display("FAIL single_final: busy %b error %b want 0/0", busyOut, error); end
    endtask

    task automatic test_multi_burst();
        int b0 = bAddr.size(), d0 = dData.size(), p0 = nPops;
        bit to;
        load_random(20);
        model(32'h1000, 20, -1);
        run_xfer(32'h1000, 16'd20, to);
        tests++; if (to) begin fails++; $display("FAIL multi_done_timeout: no done seen"); end
        tests++; if (bAddr.size() - b0 != expA.size()) begin
            fails++; $display("FAIL multi_bursts: got %0d want %0d", bAddr.size() - b0, expA.size()); end
        for (int i = 0; i < expA.size() && b0 + i < bAddr.size(); i++) begin
            tests++; if (bAddr[b0 + i] !== expA[i] || bLen[b0 + i] !== expL[i]) begin
                fails++; $display("FAIL multi_hdr%0d: got %h/%0d want %h/%0d", i, bAddr[b0 + i], bLen[b0 + i], expA[i], expL[i]); end
        end
        tests++; if (dData.size() - d0 != expD.size()) begin
            fails++; $display("FAIL multi_beats: got %0d want %0d", dData.size() - d0, expD.size()); end
        for (int i = 0; i < expD.size() && d0 + i < dData.size(); i++) begin
            tests++; if (dData[d0 + i] !== expD[i]) begin
                fails++; $display("FAIL multi_data%0d: got %h want %h", i, dData[d0 + i], expD[i]); end
        end
        tests++; if (nPops - p0 != expPops) begin fails++; $display("FAIL multi_pops: got %0d want %0d", nPops - p0, expPops); end
    endtask

    task automatic test_zero_words();
        int b0 = bAddr.size(), p0 = nPops, e0 = nDone;
        bit to;
        run_xfer(32'h4000, 16'd0, to);
        tests++; if (to || nDone - e0 != 1) begin fails++; $display("FAIL zero_done: got %0d pulses want 1", nDone - e0); end
        tests++; if (bAddr.size() != b0 || nPops != p0) begin
            fails++; $display("FAIL zero_activity: bursts %0d pops %0d want 0/0", bAddr.size() - b0, nPops - p0); end
    endtask

    task automatic test_starve();
        int b0 = bAddr.size(), d0 = dData.size(), p0 = nPops, e0 = nDone, k = 0, pStarve;
        bit to;
        load_random(8);
        model(32'h5000, 8, -1);
        pulse_start(32'h5000, 16'd8);
        while (nPops - p0 < 3 && k < 200) begin @(negedge clock); k++; end
        @(posedge clock); #1 starve = 1'b1;
        pStarve = nPops;
        repeat (5) @(posedge clock);
        tests++; if (nPops != pStarve) begin fails++; $display("FAIL starve_pop: got %0d pops want 0", nPops - pStarve); end
        tests++; if (bAddr.size() != b0) begin fails++; $display("FAIL starve_begin: got %0d bursts want 0", bAddr.size() - b0); end
        #1 starve = 1'b0;
        wait_done(e0, to);
        tests++; if (to) begin fails++; $display("FAIL starve_done_timeout: no done seen"); end
        tests++; if (bAddr.size() - b0 != 1 || bAddr[b0] !== expA[0] || bLen[b0] !== expL[0]) begin
            fails++; $display("FAIL starve_hdr: got %0d bursts, %h/%0d want 1, %h/%0d", bAddr.size() - b0, bAddr[b0], bLen[b0], expA[0], expL[0]); end
        for (int i = 0; i < expD.size() && d0 + i < dData.size(); i++) begin
            tests++; if (dData[d0 + i] !== expD[i]) begin
                fails++; $display("FAIL starve_data%0d: got %h want %h", i, dData[d0 + i], expD[i]); end
        end
    endtask

    task automatic test_busy_hold();
        int d0 = dData.size(), v0 = nDv, h0 = nBadHold;
        bit to;
        busyArm = 1'b1; busyBeat = 1; busyCycles = 3;
        load_random(8);
        model(32'h2000, 8, -1);
        run_xfer(32'h2000, 16'd8, to);
        busyArm = 1'b0;
        tests++; if (to) begin fails++; $display("FAIL busy_done_timeout: no done seen"); end
        tests++; if (nDv - v0 != 11) begin fails++; $display("FAIL busy_valid_cycles: got %0d want 11", nDv - v0); end
        tests++; if (nBadHold != h0) begin fails++; $display("FAIL busy_hold: got %0d unstable cycles want 0", nBadHold - h0); end
        tests++; if (dData.size() - d0 != expD.size()) begin
            fails++; $display("FAIL busy_beats: got %0d want %0d", dData.size() - d0, expD.size()); end
        for (int i = 0; i < expD.size() && d0 + i < dData.size(); i++) begin
            tests++; if (dData[d0 + i] !== expD[i]) begin
                fails++; $display("FAIL busy_data%0d: got %h want %h", i, dData[d0 + i], expD[i]); end
        end
    endtask

    task automatic test_error();
        int b0 = bAddr.size(), d0 = dData.size(), p0 = nPops, n0 = nEnd, e0 = nDone;
        bit to;
        logic [31:0] firstExp;
`ifdef BYTE_SWAP_EN
        firstExp = 32'h44332211;
`else
        firstExp = 32'h11223344;
`endif
        fifoQ.push_back(32'h11223344); wrCount += 1;
        load_random(19);
        errArm = 1'b1; errBeat = 3;
        model(32'h3000, 20, 3);
        run_xfer(32'h3000, 16'd20, to);
        errArm = 1'b0;
        repeat (10) @(negedge clock);
        tests++; if (to || nDone - e0 != 1) begin fails++; $display("FAIL err_done: got %0d pulses want 1", nDone - e0); end
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL err_flag: got %b want 1", error); end
        tests++; if (nEnd - n0 != 1 || bAddr.size() - b0 != 1) begin
            fails++; $display("FAIL err_framing: ends %0d bursts %0d want 1/1", nEnd - n0, bAddr.size() - b0); end
        tests++; if (nPops - p0 != expPops) begin fails++; $display("FAIL err_pops: got %0d want %0d", nPops - p0, expPops); end
        tests++; if (dData.size() - d0 != expD.size()) begin
            fails++; $display("FAIL err_beats: got %0d want %0d", dData.size() - d0, expD.size()); end
        tests++; if (dData[d0] !== firstExp) begin fails++; $display("FAIL err_swap: got %h want %h", dData[d0], firstExp); end
        for (int i = 1; i < expD.size() && d0 + i < dData.size(); i++) begin
            tests++; if (dData[d0 + i] !== expD[i]) begin
                fails++; $display("FAIL err_data%0d: got %h want %h", i, dData[d0 + i], expD[i]); end
        end
        run_xfer(32'h0, 16'd0, to);
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL err_clear: got %b want 0", error); end
    endtask

    task automatic test_ignore_start();
        int b0 = bAddr.size(), e0 = nDone;
        bit to;
        load_random(8);
        model(32'h6000, 8, -1);
        pulse_start(32'h6000, 16'd8);
        repeat (3) @(negedge clock);
        pulse_start(32'h9000, 16'd3);
        wait_done(e0, to);
        repeat (20) @(negedge clock);
        tests++; if (to || nDone - e0 != 1) begin fails++; $display("FAIL busystart_done: got %0d pulses want 1", nDone - e0); end
        tests++; if (bAddr.size() - b0 != 1 || bAddr[b0] !== expA[0] || bLen[b0] !== expL[0]) begin
            fails++; $display("FAIL busystart_hdr: got %0d bursts, %h/%0d want 1, %h/%0d", bAddr.size() - b0, bAddr[b0], bLen[b0], expA[0], expL[0]); end
    endtask

    task automatic test_reset_in_data();
        int b0, d0, k = 0, e0 = nDone;
        bit to;
        load_random(8);
        pulse_start(32'h7000, 16'd8);
        while (!dataValid && k < 500) begin @(negedge clock); k++; end
        tests++; if (dataValid !== 1'b1) begin fails++; $display("FAIL rst_reach_data: dataValid %b want 1", dataValid); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tests++;
        if ({busyOut, fifoPop, requestBus, beginTransaction, endTransaction, dataValid, done, error} !== 8'h00 ||
            addressData !== 32'd0 || burstLength !== 8'd0) begin
            fails++; $display("FAIL rst_data_outputs: got %b addr %h len %0d want all 0",
                {busyOut, fifoPop, requestBus, beginTransaction, endTransaction, dataValid, done, error}, addressData, burstLength);
        end
        tests++; if (nDone != e0) begin fails++; $display("FAIL rst_data_done: got %0d pulses want 0", nDone - e0); end
        b0 = bAddr.size(); d0 = dData.size();
        load_random(8);
        model(32'h7100, 8, -1);
        run_xfer(32'h7100, 16'd8, to);
        tests++; if (to) begin fails++; $display("FAIL rst_restart_timeout: no done seen"); end
        tests++; if (bAddr.size() - b0 != 1 || bAddr[b0] !== expA[0] || bLen[b0] !== expL[0]) begin
            fails++; $display("FAIL rst_restart_hdr: got %0d bursts, %h/%0d want 1, %h/%0d", bAddr.size() - b0, bAddr[b0], bLen[b0], expA[0], expL[0]); end
        for (int i = 0; i < expD.size() && d0 + i < dData.size(); i++) begin
            tests++; if (dData[d0 + i] !== expD[i]) begin
                fails++; $display("FAIL rst_restart_data%0d: got %h want %h", i, dData[d0 + i], expD[i]); end
        end
    endtask

    task automatic test_random();
        randGrantEn = 1'b1; randBusyEn = 1'b1;
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(0, 40);
            logic [31:0] a = $urandom;
            int b0 = bAddr.size(), d0 = dData.size(), p0 = nPops;
            bit to;
            load_random(n);
            model(a, n, -1);
            run_xfer(a, 16'(n), to);
            tests++; if (to) begin fails++; $display("FAIL rand%0d_timeout: no done seen", it); end
            tests++; if (bAddr.size() - b0 != expA.size() || dData.size() - d0 != expD.size()) begin
                fails++; $display("FAIL rand%0d_counts: bursts %0d beats %0d want %0d/%0d", it,
                    bAddr.size() - b0, dData.size() - d0, expA.size(), expD.size()); end
            for (int i = 0; i < expA.size() && b0 + i < bAddr.size(); i++) begin
                tests++; if (bAddr[b0 + i] !== expA[i] || bLen[b0 + i] !== expL[i]) begin
                    fails++; $display("FAIL rand%0d_hdr%0d: got %h/%0d want %h/%0d", it, i, bAddr[b0 + i], bLen[b0 + i], expA[i], expL[i]); end
            end
            for (int i = 0; i < expD.size() && d0 + i < dData.size(); i++) begin
                tests++; if (dData[d0 + i] !== expD[i]) begin
                    fails++; $display("FAIL rand%0d_data%0d: got %h want %h", it, i, dData[d0 + i], expD[i]); end
            end
            tests++; if (nPops - p0 != expPops) begin fails++; $display("FAIL rand%0d_pops: got %0d want %0d", it, nPops - p0, expPops); end
        end
        randGrantEn = 1'b0; randBusyEn = 1'b0;
    endtask

    task automatic test_protocol();
        tests++; if (nBadPop != 0) begin fails++; $display("FAIL proto_pop_empty: got %0d want 0", nBadPop); end
        tests++; if (nBadOut != 0) begin fails++; $display("FAIL proto_idle_bus: got %0d nonzero cycles want 0", nBadOut); end
        tests++; if (nBadHold != 0) begin fails++; $display("FAIL proto_hold: got %0d unstable cycles want 0", nBadHold); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_zero_words();
        test_starve();
        test_busy_hold();
        test_error();
        test_ignore_start();
        test_reset_in_data();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1, "watchdog expired");
    end

endmodule
